// File: rtl/systolic_skew_feeder_if.sv
// systolic_skew_feeder_if: row-stream and lane-output bundle of the skew feeder.
//   master : drives start/num_rows/row_in/row_valid (buffer + sequencer side),
//            observes row_req/lane_out/lane_valid/busy/done.
//   slave  : the feeder itself (mirror directions).
//   Lane i of row_in/lane_out occupies bits [(i+1)*DATA_W-1 : i*DATA_W].
interface systolic_skew_feeder_if #(
   parameter int unsigned ARR_SIZE = 4,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned CNT_W    = 8
);
   logic                       start;
   logic [CNT_W-1:0]           num_rows;
   logic [ARR_SIZE*DATA_W-1:0] row_in;
   logic                       row_valid;
   logic                       row_req;
   logic [ARR_SIZE*DATA_W-1:0] lane_out;
   logic [ARR_SIZE-1:0]        lane_valid;
   logic                       busy;
   logic                       done;

   modport master (
      output start, num_rows, row_in, row_valid,
      input  row_req, lane_out, lane_valid, busy, done
   );

   modport slave (
      input  start, num_rows, row_in, row_valid,
      output row_req, lane_out, lane_valid, busy, done
   );
endinterface

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: re-times packed rows into a diagonal wavefront for the
// systolic array edge. Lane i is delayed by i extra cycles (latency i+1).
// A small FSM counts the rows of a pass, drains the skew chain and pulses done.
//   clk_i : clock, rising edge
//   rst_i : synchronous, active-high reset
//   bus   : systolic_skew_feeder_if.slave (row stream in, skewed lanes out,
//           start/num_rows control, row_req/busy/done status)
module systolic_skew_feeder #(
   parameter int unsigned ARR_SIZE = 4,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned CNT_W    = 8
) (
   input logic                   clk_i,
   input logic                   rst_i,
   systolic_skew_feeder_if.slave bus
);
   localparam int unsigned FlushW = $clog2(ARR_SIZE);

   typedef enum logic [1:0] {StIdle, StLoad, StFlush, StDone} state_e;

   state_e            state_q;
   logic [CNT_W-1:0]  rows_left_q;
   logic [FlushW-1:0] flush_cnt_q;
   logic              row_req_q;
   logic              busy_q;
   logic              done_q;
   logic              accept;

   // Only rows offered while loading are taken; everything else is a bubble.
   assign accept = (state_q == StLoad) && bus.row_valid;

   assign bus.row_req = row_req_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;

   // Control FSM; status outputs are registered alongside the state so they
   // always match the state they decode.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         rows_left_q <= '0;
         flush_cnt_q <= '0;
         row_req_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  rows_left_q <= bus.num_rows;
                  busy_q      <= 1'b1;
                  if (bus.num_rows == '0) begin
                     state_q <= StDone;
                     done_q  <= 1'b1;
                  end else begin
                     state_q   <= StLoad;
                     row_req_q <= 1'b1;
                  end
               end
            end
            StLoad: begin
               if (bus.row_valid) begin
                  rows_left_q <= rows_left_q - 1'b1;
                  if (rows_left_q == CNT_W'(1)) begin
                     state_q     <= StFlush;
                     row_req_q   <= 1'b0;
                     flush_cnt_q <= FlushW'(ARR_SIZE - 1);
                  end
               end
            end
            StFlush: begin
               flush_cnt_q <= flush_cnt_q - 1'b1;
               if (flush_cnt_q == FlushW'(1)) begin
                  state_q <= StDone;
                  done_q  <= 1'b1;
               end
            end
            StDone: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Skew chains: lane i holds i+1 stages; the last stage drives the output.
   for (genvar i = 0; i < ARR_SIZE; i++) begin : g_lane
      logic [DATA_W-1:0] data_q  [i+1];
      logic              valid_q [i+1];
      logic [DATA_W-1:0] inj_data;

      assign inj_data = accept ? bus.row_in[i*DATA_W +: DATA_W] : '0;

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            for (int s = 0; s <= i; s++) begin
               data_q[s]  <= '0;
               valid_q[s] <= 1'b0;
            end
         end else begin
            data_q[0]  <= inj_data;
            valid_q[0] <= accept;
            for (int s = 1; s <= i; s++) begin
               data_q[s]  <= data_q[s-1];
               valid_q[s] <= valid_q[s-1];
            end
         end
      end

      assign bus.lane_out[i*DATA_W +: DATA_W] = data_q[i];
      assign bus.lane_valid[i]                = valid_q[i];
   end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder: directed table, hand-written corner sequences and
// random traffic, all compared cycle by cycle against a timestamp/queue model.
module tb_systolic_skew_feeder;
   localparam int N  = 4;
   localparam int W  = 16;
   localparam int CW = 8;
   localparam int LW = N * W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   systolic_skew_feeder_if #(.ARR_SIZE(N), .DATA_W(W), .CNT_W(CW)) bus ();

   systolic_skew_feeder #(.ARR_SIZE(N), .DATA_W(W), .CNT_W(CW)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: expected lane i in a cycle = row injected i+1 cycles ago;
   // pass milestones are kept as absolute cycle stamps.
   int            cyc;
   bit            m_busy, m_ld;
   int            m_rows, m_done_at, m_idle_at;
   logic [LW-1:0] q_data [$];
   bit            q_val  [$];

   int n_done, n_beats, last_done_cyc;
   bit seen_req, seen_lv;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
      end
   endfunction

   function automatic void model_reset();
      m_busy = 0; m_ld = 0; m_rows = 0; m_done_at = -1; m_idle_at = -1;
      q_data.delete();
      q_val.delete();
   endfunction

   function automatic void model_edge();
      bit acc;
      if (rst) begin
         model_reset();
         return;
      end
      acc = m_ld && bus.row_valid;
      q_data.push_front(acc ? bus.row_in : '0);
      q_val.push_front(acc);
      if (q_data.size() > N) begin
         void'(q_data.pop_back());
         void'(q_val.pop_back());
      end
      if (!m_busy && bus.start) begin
         m_busy = 1;
         if (bus.num_rows == 0) begin
            m_done_at = cyc + 1;
            m_idle_at = cyc + 2;
         end else begin
            m_ld   = 1;
            m_rows = int'(bus.num_rows);
         end
      end else if (acc) begin
         m_rows--;
         if (m_rows == 0) begin
            m_ld      = 0;
            m_done_at = cyc + N;
            m_idle_at = cyc + N + 1;
         end
      end
   endfunction

   // Check the current cycle's outputs, then advance one clock.
   task automatic step();
      logic [LW-1:0] e_lo;
      logic [N-1:0]  e_lv;
      e_lo = '0;
      e_lv = '0;
      for (int i = 0; i < N; i++) begin
         if (i < q_data.size()) begin
            e_lo[i*W +: W] = q_data[i][i*W +: W];
            e_lv[i]        = q_val[i];
         end
      end
      chk("lane_out", bus.lane_out, e_lo);
      chk("lane_valid", bus.lane_valid, e_lv);
      chk("row_req", bus.row_req, m_ld);
      chk("busy", bus.busy, m_busy);
      chk("done", bus.done, (cyc == m_done_at));
      if (bus.done) begin
         n_done++;
         last_done_cyc = cyc;
      end
      n_beats += $countones(bus.lane_valid);
      seen_req |= bus.row_req;
      seen_lv  |= (|bus.lane_valid);
      model_edge();
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == m_idle_at) m_busy = 0;
   endtask

   task automatic drive(bit s, logic [CW-1:0] n, bit v, logic [LW-1:0] r);
      bus.start     = s;
      bus.num_rows  = n;
      bus.row_valid = v;
      bus.row_in    = r;
   endtask

   task automatic idle(int k);
      drive(0, '0, 0, '0);
      for (int j = 0; j < k; j++) step();
   endtask

   function automatic logic [LW-1:0] rnd_row();
      return {$urandom(), $urandom()};
   endfunction

   typedef struct {
      logic          start;
      logic [CW-1:0] num;
      logic          rv;
      logic [LW-1:0] row;
      logic [LW-1:0] e_lo;
      logic [N-1:0]  e_lv;
      logic          e_req;
      logic          e_busy;
      logic          e_done;
   } vec_t;

   function automatic vec_t mk(logic s, logic [CW-1:0] n, logic rv, logic [LW-1:0] row,
                               logic [LW-1:0] lo, logic [N-1:0] lv, logic rq, logic bz,
                               logic dn);
      vec_t v;
      v.start = s; v.num = n; v.rv = rv; v.row = row;
      v.e_lo = lo; v.e_lv = lv; v.e_req = rq; v.e_busy = bz; v.e_done = dn;
      return v;
   endfunction

   vec_t tbl [10];

   initial begin
      logic [LW-1:0] r0, r1, r2;
      int sa, nd0;
      r0 = 64'h0003_0002_0001_0000;
      r1 = 64'h0103_0102_0101_0100;
      r2 = 64'h0203_0202_0201_0200;
      // Basic pass: start at t0, rows at t2..t4, row r lane i = 16'h0r0i.
      tbl[0] = mk(1, 3, 0, '0, '0, 4'b0000, 0, 0, 0);
      tbl[1] = mk(0, 0, 0, '0, '0, 4'b0000, 1, 1, 0);
      tbl[2] = mk(0, 0, 1, r0, '0, 4'b0000, 1, 1, 0);
      tbl[3] = mk(0, 0, 1, r1, 64'h0000_0000_0000_0000, 4'b0001, 1, 1, 0);
      tbl[4] = mk(0, 0, 1, r2, 64'h0000_0000_0001_0100, 4'b0011, 1, 1, 0);
      tbl[5] = mk(0, 0, 0, '0, 64'h0000_0002_0101_0200, 4'b0111, 0, 1, 0);
      tbl[6] = mk(0, 0, 0, '0, 64'h0003_0102_0201_0000, 4'b1110, 0, 1, 0);
      tbl[7] = mk(0, 0, 0, '0, 64'h0103_0202_0000_0000, 4'b1100, 0, 1, 0);
      tbl[8] = mk(0, 0, 0, '0, 64'h0203_0000_0000_0000, 4'b1000, 0, 1, 1);
      tbl[9] = mk(0, 0, 0, '0, '0, 4'b0000, 0, 0, 0);

      n_done = 0; n_beats = 0; last_done_cyc = -100; seen_req = 0; seen_lv = 0;
      cyc = 0;
      drive(0, '0, 0, '0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      rst = 1'b0;

      for (int t = 0; t < 10; t++) begin
         drive(tbl[t].start, tbl[t].num, tbl[t].rv, tbl[t].row);
         chk("tbl_lane_out", bus.lane_out, tbl[t].e_lo);
         chk("tbl_lane_valid", bus.lane_valid, tbl[t].e_lv);
         chk("tbl_row_req", bus.row_req, tbl[t].e_req);
         chk("tbl_busy", bus.busy, tbl[t].e_busy);
         chk("tbl_done", bus.done, tbl[t].e_done);
         step();
      end

      // Bubble: two rows with a gap between them.
      drive(1, 2, 0, '0); step();
      drive(0, 0, 1, rnd_row()); step();
      drive(0, 0, 0, '0); step();
      drive(0, 0, 1, rnd_row()); sa = cyc; step();
      idle(7);
      chk("bubble_done_latency", last_done_cyc - sa, 4);

      // Zero rows.
      seen_req = 0; seen_lv = 0;
      drive(1, 0, 0, '0); sa = cyc; step();
      idle(4);
      chk("zero_done_latency", last_done_cyc - sa, 1);
      chk("zero_row_req", seen_req, 0);
      chk("zero_lane_valid", seen_lv, 0);

      // Start during LOAD is ignored; all-ones rows during FLUSH/DONE never leak.
      drive(1, 3, 0, '0); step();
      drive(1, 1, 0, '0); step();
      drive(0, 0, 1, rnd_row()); step();
      drive(1, 7, 1, rnd_row()); step();
      drive(0, 0, 1, rnd_row()); sa = cyc; step();
      drive(0, 0, 1, {LW{1'b1}});
      for (int j = 0; j < 4; j++) step();
      idle(3);
      chk("ignore_done_latency", last_done_cyc - sa, 4);

      // Reset in the second FLUSH cycle.
      drive(1, 1, 0, '0); step();
      drive(0, 0, 1, rnd_row()); step();
      drive(0, 0, 0, '0); step();
      rst = 1'b1; step();
      rst = 1'b0;
      chk("rst_lane_out", bus.lane_out, '0);
      chk("rst_status", {bus.lane_valid, bus.row_req, bus.busy, bus.done}, '0);
      nd0 = n_done;
      idle(6);
      chk("rst_no_done", n_done, nd0);
      drive(1, 1, 0, '0); step();
      drive(0, 0, 1, rnd_row()); sa = cyc; step();
      idle(6);
      chk("rst_then_pass_latency", last_done_cyc - sa, 4);

      // Back-to-back 2-row passes, second start in first IDLE cycle after done.
      n_done = 0; n_beats = 0;
      for (int k = 0; k < 18; k++) begin
         drive((k == 0) || (k == 7), 2, (k == 1) || (k == 2) || (k == 8) || (k == 9),
               rnd_row());
         step();
      end
      chk("b2b_done_count", n_done, 2);
      chk("b2b_valid_beats", n_beats, 16);

      // Random traffic against the model.
      for (int k = 0; k < 2000; k++) begin
         rst = ($urandom_range(0, 199) == 0);
         drive($urandom_range(0, 7) == 0, CW'($urandom_range(0, 5)),
               $urandom_range(0, 2) != 0, rnd_row());
         step();
      end
      rst = 1'b0;
      idle(8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
